// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative shift-add multiplier / restoring divider owning HI/LO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum, w_t;
  logic [WIDTH-1:0]   w_diff, w_rrem;
  logic               w_ge, w_neg_res;
  logic [2*WIDTH-1:0] w_mul, w_div, w_step, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  always_comb begin
    w_signed = ~op_q[0];
    w_mag_a  = (w_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    w_mag_b  = (w_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // p holds {partial product, multiplier} or {remainder, dividend/quotient}
    w_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
    w_mul  = {w_sum, p_q[WIDTH-1:1]};
    w_t    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    w_ge   = (w_t >= {1'b0, m_q});
    w_diff = w_t[WIDTH-1:0] - m_q;
    w_rrem = w_ge ? w_diff : w_t[WIDTH-1:0];
    w_div  = {w_rrem, p_q[WIDTH-2:0], w_ge};
    w_step = op_q[1] ? w_div : w_mul;

    w_neg_res = neg_a_q ^ neg_b_q;
    w_prod    = w_neg_res ? -w_step : w_step;
    w_quo     = w_neg_res ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    w_rem     = neg_a_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_LOAD: begin
        neg_a_d = w_signed & a_q[WIDTH-1];
        neg_b_d = w_signed & b_q[WIDTH-1];
        m_d     = w_mag_b;
        p_d     = {{WIDTH{1'b0}}, w_mag_a};
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        p_d   = w_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          done_d  = 1'b1;
          state_d = S_FIX;
          if (!op_q[1]) begin
            {hi_d, lo_d} = w_prod;
          end else if (m_q == '0) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_q;
          end else begin
            lo_d = w_quo;
            hi_d = w_rem;
          end
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
